// File: rtl/ha_array_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ha_array_pkg
// Description : Shared constants, state encoding and row-pair type for the
//               half-adder-array product accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package ha_array_pkg;

    localparam int NUM_ROWS  = 4;
    localparam int B_W       = 7;
    localparam int T_W       = 9;
    localparam int ROW_SHIFT = 2;
    localparam int OUT_W     = 16;
    localparam int B_OFFSET  = 2;
    localparam int ACC_W     = OUT_W + 1;
    localparam int ROW_IDX_W = $clog2(NUM_ROWS);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ACC  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = c_ST_IDLE,
        ACC  = c_ST_ACC,
        DONE = c_ST_DONE
    } state_t;

    typedef struct packed {
        logic [B_W-1:0] b;
        logic [T_W-1:0] t;
    } row_pair_t;

endpackage
`default_nettype wire

// File: rtl/ha_row_weight.sv
`default_nettype none
// ============================================================================
// Module      : ha_row_weight
// Description : Combinational weighting of one b/t row pair by its row index.
// Revision    : 1.0 - initial release
// ============================================================================
module ha_row_weight
    import ha_array_pkg::*;
(
    input  row_pair_t              row,
    input  logic [ROW_IDX_W-1:0]   row_idx,
    output logic [ACC_W-1:0]       row_val
);

    logic [ACC_W-1:0] w_t_ext;
    logic [ACC_W-1:0] w_b_ext;
    logic [4:0]       w_t_shamt;
    logic [4:0]       w_b_shamt;

    // The b vector is a carry row, so it sits two bits above its t partner.
    always_comb begin
        w_t_ext   = ACC_W'(row.t);
        w_b_ext   = ACC_W'(row.b);
        w_t_shamt = 5'(row_idx) * 5'(ROW_SHIFT);
        w_b_shamt = w_t_shamt + 5'(B_OFFSET);
        row_val   = (w_t_ext << w_t_shamt) + (w_b_ext << w_b_shamt);
    end

endmodule
`default_nettype wire

// File: rtl/ha_array_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : ha_array_accumulator
// Description : Accepts one beat of four compressed rows and reduces them over
//               four cycles into a 16-bit product with a valid/ready output.
//               Define HA_ACC_SATURATE_EN to clamp the product to 16'hFFFF on
//               overflow; otherwise the product wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module ha_array_accumulator
    import ha_array_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [B_W-1:0]   ha_array_0_b,
    input  logic [B_W-1:0]   ha_array_1_b,
    input  logic [B_W-1:0]   ha_array_2_b,
    input  logic [B_W-1:0]   ha_array_3_b,
    input  logic [T_W-1:0]   ha_array_0_t,
    input  logic [T_W-1:0]   ha_array_1_t,
    input  logic [T_W-1:0]   ha_array_2_t,
    input  logic [T_W-1:0]   ha_array_3_t,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] product,
    output logic             overflow
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    row_pair_t              r_rows [NUM_ROWS];
    row_pair_t              w_in_rows [NUM_ROWS];
    logic [ACC_W-1:0]       r_acc;
    logic [ROW_IDX_W-1:0]   r_row_idx;
    logic                   r_ovf;
    logic [ACC_W-1:0]       w_row_val;
    logic [ACC_W:0]         w_sum;
    logic                   w_accept;
    logic                   w_last_row;
    logic                   w_ovf_total;

    assign w_in_rows[0] = '{b: ha_array_0_b, t: ha_array_0_t};
    assign w_in_rows[1] = '{b: ha_array_1_b, t: ha_array_1_t};
    assign w_in_rows[2] = '{b: ha_array_2_b, t: ha_array_2_t};
    assign w_in_rows[3] = '{b: ha_array_3_b, t: ha_array_3_t};

    assign w_accept   = in_valid & in_ready;
    assign w_last_row = (r_row_idx == ROW_IDX_W'(NUM_ROWS - 1));

    // A single weighting unit is time-shared across rows.
    ha_row_weight u_row_weight (
        .row     (r_rows[r_row_idx]),
        .row_idx (r_row_idx),
        .row_val (w_row_val)
    );

    assign w_sum = {1'b0, r_acc} + {1'b0, w_row_val};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = ACC;
                end
            end
            ACC: begin
                if (w_last_row) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ROWS; i++) begin
                r_rows[i] <= '0;
            end
            r_acc     <= '0;
            r_row_idx <= '0;
            r_ovf     <= 1'b0;
        end else if (w_accept) begin
            r_rows    <= w_in_rows;
            r_acc     <= '0;
            r_row_idx <= '0;
            r_ovf     <= 1'b0;
        end else if (r_state == ACC) begin
            r_acc     <= w_sum[ACC_W-1:0];
            r_ovf     <= r_ovf | w_sum[ACC_W];
            r_row_idx <= r_row_idx + ROW_IDX_W'(1);
        end
    end

    // The guard bit of acc holds the 2^16 weight; any carry beyond it is sticky.
    assign w_ovf_total = r_ovf | r_acc[ACC_W-1];
    assign overflow    = w_ovf_total;

`ifdef HA_ACC_SATURATE_EN
    assign product = w_ovf_total ? {OUT_W{1'b1}} : r_acc[OUT_W-1:0];
`else
    assign product = r_acc[OUT_W-1:0];
`endif

endmodule
`default_nettype wire

// File: tb/tb_ha_array_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_ha_array_accumulator
// Description : Directed self-checking bench for ha_array_accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ha_array_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;
    logic [15:0] product;
    logic [6:0]  b0, b1, b2, b3;
    logic [8:0]  t0, t1, t2, t3;

    logic [6:0]  st_b [4];
    logic [8:0]  st_t [4];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ha_array_accumulator dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ha_array_0_b (b0),
        .ha_array_1_b (b1),
        .ha_array_2_b (b2),
        .ha_array_3_b (b3),
        .ha_array_0_t (t0),
        .ha_array_1_t (t1),
        .ha_array_2_t (t2),
        .ha_array_3_t (t3),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .overflow     (overflow)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic clear_stim();
        for (int i = 0; i < 4; i++) begin
            st_b[i] = '0;
            st_t[i] = '0;
        end
    endtask

    task automatic drive_stim();
        b0 = st_b[0]; b1 = st_b[1]; b2 = st_b[2]; b3 = st_b[3];
        t0 = st_t[0]; t1 = st_t[1]; t2 = st_t[2]; t3 = st_t[3];
    endtask

    // Garbage on the row inputs outside the accept cycle must not matter.
    task automatic drive_garbage();
        b0 = 7'($urandom); b1 = 7'($urandom); b2 = 7'($urandom); b3 = 7'($urandom);
        t0 = 9'($urandom); t1 = 9'($urandom); t2 = 9'($urandom); t3 = 9'($urandom);
    endtask

    task automatic wait_ready(input string tag);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check_val({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic do_beat(input string tag, input int hold, input int exp_p, input bit exp_o);
        int lat;
        logic [15:0] held_p;
        wait_ready(tag);
        drive_stim();
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drive_garbage();
        check_val({tag, "_busy"}, 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val({tag, "_latency"}, 32'(lat), 32'd4);
        check_val({tag, "_product"}, 32'(product), 32'(exp_p));
        check_val({tag, "_overflow"}, 32'(overflow), 32'(exp_o));
        if (hold > 0) begin
            held_p   = product;
            in_valid = 1'b1;
            for (int k = 0; k < hold; k++) begin
                @(posedge clk); #1;
                check_val({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
                check_val({tag, "_hold_product"}, 32'(product), 32'(held_p));
                check_val({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check_val({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check_val({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clear_stim();
        drive_stim();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_product", 32'(product), 32'd0);
        check_val("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        clear_stim();
        do_beat("zero", 0, 0, 1'b0);

        clear_stim(); st_t[0] = 9'h001;
        do_beat("t0_lsb", 0, 1, 1'b0);

        clear_stim(); st_b[3] = 7'h40;
        do_beat("b3_msb", 0, 16384, 1'b0);

        clear_stim(); st_t[1] = 9'h003; st_b[2] = 7'h01;
        do_beat("mixed", 0, 76, 1'b0);

        for (int i = 0; i < 4; i++) begin
            st_b[i] = 7'h7F;
            st_t[i] = 9'h1FF;
        end
`ifdef HA_ACC_SATURATE_EN
        do_beat("all_ones", 0, 65535, 1'b1);
`else
        do_beat("all_ones", 0, 21079, 1'b1);
`endif

        clear_stim(); st_t[1] = 9'h003; st_b[2] = 7'h01;
        do_beat("backpressure", 10, 76, 1'b0);

        // Abort an overflowing beat in its second accumulate cycle.
        for (int i = 0; i < 4; i++) begin
            st_b[i] = 7'h7F;
            st_t[i] = 9'h1FF;
        end
        wait_ready("abort");
        drive_stim();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_val("abort_out_valid", 32'(out_valid), 32'd0);
        check_val("abort_in_ready", 32'(in_ready), 32'd1);
        check_val("abort_product", 32'(product), 32'd0);
        check_val("abort_overflow", 32'(overflow), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_val("abort_never_presented", 32'(out_valid), 32'd0);

        clear_stim(); st_t[0] = 9'h001;
        do_beat("after_abort", 0, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
